anode_scan_timer: RTL and testbench

- Parametrised scan timer for multiplexed 7-segment displays.
- Divides clk by a runtime-loadable period and emits a one-cycle tick.
- Advances a digit index on each tick and drives a one-hot, active-low anode vector.
- Adds enable, period reload, 0/1 period clamping and a wrap pulse for frame-synchronous logic.

---
 rtl/scan_pkg.sv | 33 +++
 rtl/period_counter.sv | 68 ++++++
 rtl/anode_scan_timer.sv | 87 ++++++++
 tb/tb_anode_scan_timer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared constants and helpers for the anode scan timer.
//   DEFAULT_PERIOD_2MS  : 2 ms digit period at 100 MHz
//   DEFAULT_PERIOD_1KHZ : 1 ms digit period at 100 MHz
//   DEFAULT_N_DIGITS    : number of anodes on the standard display board
//   clog2()             : ceiling log2, used to size the digit index
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int DEFAULT_PERIOD_2MS  = 200000;
  localparam int DEFAULT_PERIOD_1KHZ = 100000;
  localparam int DEFAULT_N_DIGITS    = 8;

  // Ceiling log2; returns at least 1 so a 1-entry range still gets a bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/period_counter.sv
// -----------------------------------------------------------------------------
// period_counter
// Runtime-loadable clock divider producing a one-cycle tick every
// "period" enabled cycles. The period is held as a terminal count
// (period - 1) so the compare is a straight equality.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   count enable; low freezes count and period
//   period_ld  in   one-cycle strobe, loads period_in and restarts count
//   period_in  in   new period in clk cycles (0 is treated as 1)
//   tick       out  combinational pulse on the terminal-count cycle
// -----------------------------------------------------------------------------
module period_counter
  import scan_pkg::*;
#(
  parameter int CNT_W          = 18,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_2MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             period_ld,
  input  logic [CNT_W-1:0] period_in,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEFAULT_TC = CNT_W'(DEFAULT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] load_tc_s;
  logic             tc_s;

  // Terminal-count compare and the load clamp (0 and 1 both map to tc 0).
  always_comb begin
    tc_s = (count_r == period_r);
    if (period_in == CNT_ZERO) begin
      load_tc_s = CNT_ZERO;
    end else begin
      load_tc_s = period_in - CNT_ONE;
    end
  end

  // A load suppresses the tick so the restarted count never double-fires.
  assign tick = en & tc_s & ~period_ld;

  // Period register and cycle counter: load > hold > terminal > increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r <= DEFAULT_TC;
      count_r  <= CNT_ZERO;
    end else if (period_ld) begin
      period_r <= load_tc_s;
      count_r  <= CNT_ZERO;
    end else if (!en) begin
      period_r <= period_r;
      count_r  <= count_r;
    end else if (tc_s) begin
      count_r  <= CNT_ZERO;
    end else begin
      count_r  <= count_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/anode_scan_timer.sv
// -----------------------------------------------------------------------------
// anode_scan_timer
// Scan timer for multiplexed 7-segment displays. A period_counter produces
// the digit tick; this level steps the digit index, flags the frame wrap
// and decodes the active-low one-hot anode vector.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   count enable
//   period_ld  in   one-cycle strobe, loads period_in
//   period_in  in   new period in clk cycles
//   tick       out  one-cycle pulse per digit period
//   wrap       out  tick that returns digit_idx to 0
//   digit_idx  out  current digit, 0..N_DIGITS-1
//   anode_n    out  active-low one-hot anode select
// -----------------------------------------------------------------------------
module anode_scan_timer
  import scan_pkg::*;
#(
  parameter int CNT_W          = 18,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_2MS,
  parameter int N_DIGITS       = DEFAULT_N_DIGITS,
  parameter int IDX_W          = clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                period_ld,
  input  logic [CNT_W-1:0]    period_in,
  output logic                tick,
  output logic                wrap,
  output logic [IDX_W-1:0]    digit_idx,
  output logic [N_DIGITS-1:0] anode_n
);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic                tick_s;
  logic                last_s;
  logic [IDX_W-1:0]    digit_idx_r;
  logic [N_DIGITS-1:0] anode_s;

  period_counter #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_period_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .period_ld (period_ld),
    .period_in (period_in),
    .tick      (tick_s)
  );

  assign last_s = (digit_idx_r == IDX_LAST);

  // Digit index: steps on each tick and wraps after the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_idx_r <= IDX_ZERO;
    end else if (tick_s) begin
      digit_idx_r <= last_s ? IDX_ZERO : (digit_idx_r + IDX_ONE);
    end else begin
      digit_idx_r <= digit_idx_r;
    end
  end

  // Anode decode from the registered index, so it is valid during reset too.
  always_comb begin
    anode_s = {N_DIGITS{1'b1}};
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_idx_r == IDX_W'(i)) begin
        anode_s[i] = 1'b0;
      end else begin
        anode_s[i] = 1'b1;
      end
    end
  end

  assign tick      = tick_s;
  assign wrap      = tick_s & last_s;
  assign digit_idx = digit_idx_r;
  assign anode_n   = anode_s;

endmodule

// File: tb/tb_anode_scan_timer.sv
// -----------------------------------------------------------------------------
// tb_anode_scan_timer
// Directed bench for anode_scan_timer with DEFAULT_PERIOD overridden to 10.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_anode_scan_timer;

  localparam int CNT_W    = 18;
  localparam int N_DIGITS = 8;
  localparam int IDX_W    = 3;

  logic                clk;
  logic                rst;
  logic                en;
  logic                period_ld;
  logic [CNT_W-1:0]    period_in;
  logic                tick;
  logic                wrap;
  logic [IDX_W-1:0]    digit_idx;
  logic [N_DIGITS-1:0] anode_n;

  int n_tests;
  int n_fail;

  anode_scan_timer #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (10),
    .N_DIGITS       (N_DIGITS),
    .IDX_W          (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .period_ld (period_ld),
    .period_in (period_in),
    .tick      (tick),
    .wrap      (wrap),
    .digit_idx (digit_idx),
    .anode_n   (anode_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 unit.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    period_ld = 1'b0;
    period_in = 18'd0;
    #3;
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_anode", 32'(anode_n), 32'h0000_00FE);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);

    // Release reset, enable: first tick after 9 edges, then every 10.
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
    cyc(8);
    chk("first_tick_early", 32'(tick), 32'd0);
    cyc(1);
    chk("first_tick", 32'(tick), 32'd1);
    chk("first_tick_idx", 32'(digit_idx), 32'd0);
    chk("first_tick_wrap", 32'(wrap), 32'd0);
    cyc(1);
    chk("idx_after_first", 32'(digit_idx), 32'd1);
    chk("tick_after_first", 32'(tick), 32'd0);
    for (int d = 1; d < 8; d++) begin
      cyc(9);
      chk("scan_tick", 32'(tick), 32'd1);
      chk("scan_idx", 32'(digit_idx), 32'(d));
      chk("scan_wrap", 32'(wrap), (d == 7) ? 32'd1 : 32'd0);
      cyc(1);
      chk("scan_next_idx", 32'(digit_idx), 32'((d + 1) % 8));
      chk("scan_next_anode", 32'(anode_n), 32'(8'hFF & ~(8'd1 << ((d + 1) % 8))));
    end

    // Load period 4 at count 7: restart at 0, no tick on the load cycle.
    cyc(7);
    period_ld = 1'b1;
    period_in = 18'd4;
    settle();
    chk("ld4_tick", 32'(tick), 32'd0);
    cyc(1);
    period_ld = 1'b0;
    settle();
    chk("ld4_after_tick", 32'(tick), 32'd0);
    chk("ld4_after_idx", 32'(digit_idx), 32'd0);
    cyc(2);
    chk("ld4_early", 32'(tick), 32'd0);
    cyc(1);
    chk("p4_tick1", 32'(tick), 32'd1);
    cyc(1);
    chk("p4_idx1", 32'(digit_idx), 32'd1);
    cyc(3);
    chk("p4_tick2", 32'(tick), 32'd1);
    cyc(1);
    chk("p4_idx2", 32'(digit_idx), 32'd2);

    // Period 0 clamps to 1: tick every cycle, anode rotates each cycle.
    period_ld = 1'b1;
    period_in = 18'd0;
    settle();
    chk("ld0_tick", 32'(tick), 32'd0);
    cyc(1);
    period_ld = 1'b0;
    settle();
    chk("p0_tick_a", 32'(tick), 32'd1);
    chk("p0_anode_a", 32'(anode_n), 32'h0000_00FB);
    cyc(1);
    chk("p0_tick_b", 32'(tick), 32'd1);
    chk("p0_anode_b", 32'(anode_n), 32'h0000_00F7);
    cyc(1);
    chk("p0_anode_c", 32'(anode_n), 32'h0000_00EF);

    // Period 1 loaded on a terminal-count cycle: suppressed tick, idx holds.
    period_ld = 1'b1;
    period_in = 18'd1;
    settle();
    chk("ld1_tick", 32'(tick), 32'd0);
    cyc(1);
    period_ld = 1'b0;
    settle();
    chk("ld1_idx_hold", 32'(digit_idx), 32'd4);
    chk("p1_tick_a", 32'(tick), 32'd1);
    cyc(1);
    chk("p1_anode_a", 32'(anode_n), 32'h0000_00DF);
    cyc(1);
    chk("p1_anode_b", 32'(anode_n), 32'h0000_00BF);
    cyc(1);
    chk("p1_idx7", 32'(digit_idx), 32'd7);
    chk("p1_wrap7", 32'(wrap), 32'd1);
    cyc(1);
    chk("p1_idx0", 32'(digit_idx), 32'd0);
    chk("p1_tick0", 32'(tick), 32'd1);
    chk("p1_wrap0", 32'(wrap), 32'd0);

    // Back to period 10, then freeze at tc-1 for 5 cycles.
    period_ld = 1'b1;
    period_in = 18'd10;
    cyc(1);
    period_ld = 1'b0;
    settle();
    chk("ld10_idx", 32'(digit_idx), 32'd0);
    cyc(8);
    en = 1'b0;
    settle();
    chk("en_low_tick", 32'(tick), 32'd0);
    cyc(5);
    chk("frozen_tick", 32'(tick), 32'd0);
    chk("frozen_idx", 32'(digit_idx), 32'd0);
    en = 1'b1;
    settle();
    chk("reen_tick0", 32'(tick), 32'd0);
    cyc(1);
    chk("reen_tick1", 32'(tick), 32'd1);

    // Drop en on the terminal-count cycle: tick waits for re-enable.
    en = 1'b0;
    settle();
    chk("tc_en_low_tick", 32'(tick), 32'd0);
    cyc(2);
    chk("tc_frozen_tick", 32'(tick), 32'd0);
    chk("tc_frozen_idx", 32'(digit_idx), 32'd0);
    en = 1'b1;
    settle();
    chk("tc_reen_tick", 32'(tick), 32'd1);
    cyc(1);
    chk("tc_reen_idx", 32'(digit_idx), 32'd1);

    // Load on a terminal-count cycle with en high.
    cyc(9);
    chk("pre_ld_tick", 32'(tick), 32'd1);
    period_ld = 1'b1;
    period_in = 18'd10;
    settle();
    chk("ld_tc_tick", 32'(tick), 32'd0);
    chk("ld_tc_wrap", 32'(wrap), 32'd0);
    cyc(1);
    period_ld = 1'b0;
    settle();
    chk("ld_tc_idx", 32'(digit_idx), 32'd1);
    chk("ld_tc_count0", 32'(tick), 32'd0);
    cyc(8);
    chk("ld_tc_early", 32'(tick), 32'd0);
    cyc(1);
    chk("ld_tc_retick", 32'(tick), 32'd1);

    // Load period 2, scan to digit 5, then reset asynchronously.
    period_ld = 1'b1;
    period_in = 18'd2;
    cyc(1);
    period_ld = 1'b0;
    settle();
    chk("p2_idx_hold", 32'(digit_idx), 32'd1);
    cyc(1);
    chk("p2_tick", 32'(tick), 32'd1);
    cyc(7);
    chk("p2_idx5", 32'(digit_idx), 32'd5);
    chk("p2_anode5", 32'(anode_n), 32'h0000_00DF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_idx", 32'(digit_idx), 32'd0);
    chk("async_rst_anode", 32'(anode_n), 32'h0000_00FE);
    chk("async_rst_tick", 32'(tick), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(8);
    chk("rst_period_early", 32'(tick), 32'd0);
    cyc(1);
    chk("rst_period_tick", 32'(tick), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
